// File: rtl/seq_gen.sv
// -----------------------------------------------------------------------------
// seq_gen : framed serial sequence generator
//
// Each accepted request produces one frame on `seq`, one bit per clock:
//   preamble (PRE_LEN bits, MSB first) -> payload (WIDTH bits, MSB first)
//   -> optional even-parity bit -> GAP_LEN zero bits
// `done` pulses for the first IDLE cycle after the gap, and a start in that
// same cycle is accepted, so frames can run back to back.
//
// Ports
//   clk    in   rising-edge clock
//   reset  in   asynchronous active-high reset
//   start  in   frame request, honoured only while ready=1
//   data   in   WIDTH-bit payload, captured when start is accepted
//   abort  in   synchronous cancel; takes priority over start
//   seq    out  registered serial bit stream (0 whenever idle)
//   ready  out  high in IDLE
//   busy   out  high in every non-IDLE state
//   done   out  one-cycle frame-completion pulse
// -----------------------------------------------------------------------------
module seq_gen #(
  parameter int                 WIDTH     = 8,
  parameter int                 PRE_LEN   = 5,
  parameter logic [PRE_LEN-1:0] PREAMBLE  = 5'b10010,
  parameter int                 GAP_LEN   = 2,
  parameter int                 EN_PARITY = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] data,
  input  logic             abort,
  output logic             seq,
  output logic             ready,
  output logic             busy,
  output logic             done
);

  localparam int MAX_A = (PRE_LEN > WIDTH) ? PRE_LEN : WIDTH;
  localparam int MAX_L = (MAX_A > GAP_LEN) ? MAX_A : GAP_LEN;
  localparam int CW    = (MAX_L > 1) ? $clog2(MAX_L) : 1;

  localparam logic [CW-1:0] PRE_LAST  = CW'(PRE_LEN - 1);
  localparam logic [CW-1:0] DATA_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_LEN - 1);

  typedef enum logic [2:0] {IDLE, PRE, DATA, PAR, GAP} state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q,   cnt_d;
  logic [PRE_LEN-1:0] pre_q,   pre_d;   // preamble shifter, MSB is current bit
  logic [WIDTH-1:0]   pay_q,   pay_d;   // latched payload, shifted while in DATA
  logic               par_q,   par_d;   // parity computed once at acceptance
  logic               seq_q,   seq_d;
  logic               done_q,  done_d;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pre_q   <= '0;
      pay_q   <= '0;
      par_q   <= 1'b0;
      seq_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pre_q   <= pre_d;
      pay_q   <= pay_d;
      par_q   <= par_d;
      seq_q   <= seq_d;
      done_q  <= done_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pre_d   = pre_q;
    pay_d   = pay_q;
    par_d   = par_q;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = PRE;
          cnt_d   = '0;
          pre_d   = PREAMBLE;
          pay_d   = data;
          par_d   = ^data;
        end
      end
      PRE: begin
        if (cnt_q == PRE_LAST) begin
          state_d = DATA;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
          pre_d = pre_q << 1;
        end
      end
      DATA: begin
        if (cnt_q == DATA_LAST) begin
          state_d = (EN_PARITY != 0) ? PAR : GAP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
          pay_d = pay_q << 1;
        end
      end
      PAR: begin
        state_d = GAP;
        cnt_d   = '0;
      end
      GAP: begin
        if (cnt_q == GAP_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    // Abort wins over everything, including a start seen in IDLE: nothing
    // is latched and no done pulse is produced.
    if (abort) begin
      state_d = IDLE;
      cnt_d   = '0;
      pre_d   = pre_q;
      pay_d   = pay_q;
      par_d   = par_q;
      done_d  = 1'b0;
    end
  end

  // Output logic: seq is registered, so its next value follows the next state
  always_comb begin
    seq_d = 1'b0;
    case (state_d)
      PRE:     seq_d = pre_d[PRE_LEN-1];
      DATA:    seq_d = pay_d[WIDTH-1];
      PAR:     seq_d = par_d;
      default: seq_d = 1'b0;
    endcase
  end

  assign seq   = seq_q;
  assign done  = done_q;
  assign ready = (state_q == IDLE);
  assign busy  = (state_q != IDLE);

endmodule

// File: tb/tb_seq_gen.sv
// -----------------------------------------------------------------------------
// tb_seq_gen : scoreboard bench for seq_gen (default parameters).
// The stimulus side runs a frame-level reference model at every clock edge and
// queues the expected (seq, busy, done) for the following cycle; an
// independent monitor pops one entry per cycle on the falling edge and
// compares it with the DUT outputs.
// -----------------------------------------------------------------------------
module tb_seq_gen;

  localparam int             W   = 8;
  localparam int             PL  = 5;
  localparam int             GL  = 2;
  localparam int             EP  = 1;
  localparam logic [PL-1:0]  PRE = 5'b10010;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic         abort;
  logic [W-1:0] data;
  logic         seq;
  logic         ready;
  logic         busy;
  logic         done;

  seq_gen #(
    .WIDTH    (W),
    .PRE_LEN  (PL),
    .PREAMBLE (PRE),
    .GAP_LEN  (GL),
    .EN_PARITY(EP)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .start(start),
    .data (data),
    .abort(abort),
    .seq  (seq),
    .ready(ready),
    .busy (busy),
    .done (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic seq;
    logic busy;
    logic done;
  } rec_t;

  rec_t  exp_q[$];     // expected outputs, one entry per upcoming cycle
  rec_t  pending[$];   // remainder of the frame the model is sending
  rec_t  cur;          // what the outputs are expected to be right now
  int    n_checks = 0;
  int    n_fail   = 0;
  string phase    = "init";

  function automatic rec_t mk(input logic s, input logic b, input logic d);
    rec_t r;
    r.seq  = s;
    r.busy = b;
    r.done = d;
    return r;
  endfunction

  task automatic check(input string name, input logic act, input logic expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s/%s: got %b expected %b at %0t", phase, name, act, expv, $time);
    end
  endtask

  // Whole frame built from the frame-format rules, followed by the done cycle
  task automatic load_frame(input logic [W-1:0] d);
    logic [PL-1:0] p;
    p = PRE;
    pending.delete();
    for (int i = 0; i < PL; i++) pending.push_back(mk(p[PL-1-i], 1'b1, 1'b0));
    for (int i = 0; i < W; i++)  pending.push_back(mk(d[W-1-i], 1'b1, 1'b0));
    if (EP != 0)                 pending.push_back(mk(^d, 1'b1, 1'b0));
    for (int i = 0; i < GL; i++) pending.push_back(mk(1'b0, 1'b1, 1'b0));
    pending.push_back(mk(1'b0, 1'b0, 1'b1));
  endtask

  task automatic model_edge(input logic s, input logic [W-1:0] d, input logic a);
    rec_t nxt;
    if (reset) begin
      pending.delete();
      nxt = mk(1'b0, 1'b0, 1'b0);
    end else if (a) begin
      pending.delete();
      nxt = mk(1'b0, 1'b0, 1'b0);
    end else if (!cur.busy && s) begin
      load_frame(d);
      nxt = pending.pop_front();
    end else if (pending.size() > 0) begin
      nxt = pending.pop_front();
    end else begin
      nxt = mk(1'b0, 1'b0, 1'b0);
    end
    cur = nxt;
    exp_q.push_back(nxt);
  endtask

  // Drive inputs, let one rising edge consume them, update the model
  task automatic step(input logic s, input logic [W-1:0] d, input logic a);
    start = s;
    data  = d;
    abort = a;
    @(posedge clk);
    model_edge(s, d, a);
    #1;
  endtask

  task automatic idle_steps(input int n);
    for (int i = 0; i < n; i++) step(1'b0, W'($urandom), 1'b0);
  endtask

  // Monitor
  initial begin
    rec_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("seq",   seq,   e.seq);
        check("done",  done,  e.done);
        check("busy",  busy,  e.busy);
        check("ready", ready, !e.busy);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic         s_r;
    logic         a_r;
    cur   = mk(1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    data  = '0;

    phase = "reset";
    #12;
    check("seq",   seq,   1'b0);
    check("done",  done,  1'b0);
    check("busy",  busy,  1'b0);
    check("ready", ready, 1'b1);
    @(posedge clk);
    #1 reset = 1'b0;

    phase = "frame_a5";
    step(1'b1, 8'hA5, 1'b0);
    idle_steps(17);

    phase = "frame_01";
    step(1'b1, 8'h01, 1'b0);
    idle_steps(17);

    phase = "back_to_back";
    step(1'b1, 8'hA5, 1'b0);
    idle_steps(16);
    step(1'b1, 8'hFF, 1'b0);   // lands in the done cycle
    idle_steps(17);

    phase = "restart_ignored";
    step(1'b1, 8'hA5, 1'b0);
    idle_steps(7);
    step(1'b1, 8'h00, 1'b0);   // during DATA
    idle_steps(17);

    phase = "abort";
    step(1'b1, 8'hA5, 1'b0);
    idle_steps(7);             // third payload bit now on seq
    step(1'b0, 8'h00, 1'b1);
    idle_steps(2);
    step(1'b1, 8'h3C, 1'b0);
    idle_steps(17);

    phase = "reset_mid";
    step(1'b1, 8'hA5, 1'b0);
    idle_steps(2);
    #1 reset = 1'b1;
    #1;
    check("seq_async",   seq,   1'b0);
    check("busy_async",  busy,  1'b0);
    check("ready_async", ready, 1'b1);
    check("done_async",  done,  1'b0);
    exp_q.delete();
    exp_q.push_back(mk(1'b0, 1'b0, 1'b0));
    pending.delete();
    cur = mk(1'b0, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0);
    reset = 1'b0;
    step(1'b1, 8'h5A, 1'b0);
    idle_steps(17);

    phase = "random";
    for (int i = 0; i < 400; i++) begin
      s_r = ($urandom_range(0, 3) == 0);
      a_r = ($urandom_range(0, 39) == 0);
      step(s_r, W'($urandom), a_r);
    end
    idle_steps(20);

    @(negedge clk);
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
